// File: rtl/serial_rx.sv
// serial_rx: 8N1 UART receiver with a two-flop input synchronizer, a
// single-byte holding register, and framing/overrun error pulses.
module serial_rx #(
   parameter int CLK_FREQ  = 12_000_000,
   parameter int BAUD_RATE = 115_200
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx,
   input  logic       i_rd,
   output logic       o_rdy,
   output logic [7:0] o_data,
   output logic       o_ferr,
   output logic       o_ovr
);
   localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
   localparam int HALF_DIV = BAUD_DIV / 2;
   localparam int TW = $clog2(BAUD_DIV);
   localparam logic [TW-1:0] HALF_LOAD = TW'(HALF_DIV - 1);
   localparam logic [TW-1:0] BAUD_LOAD = TW'(BAUD_DIV - 1);
   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START     = 3'd1;
   localparam logic [2:0] DATA      = 3'd2;
   localparam logic [2:0] STOP      = 3'd3;
   localparam logic [2:0] WAIT_HIGH = 3'd4;

   logic          rx_meta, rxs;
   logic [2:0]    state, next;
   logic [TW-1:0] timer;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          sample, done, frame_err;

   always_ff @(posedge i_clk)
      if (i_rst) {rx_meta, rxs} <= 2'b11;
      else {rx_meta, rxs} <= {i_rx, rx_meta};

   always_ff @(posedge i_clk)
      if (i_rst) state <= IDLE;
      else state <= next;

   always_comb begin
      next = state;
      case (state)
         IDLE:      next = rxs ? IDLE : START;
         START:     if (sample) next = rxs ? IDLE : DATA;
         DATA:      if (sample && bit_idx == 3'd7) next = STOP;
         STOP:      if (sample) next = rxs ? IDLE : WAIT_HIGH;
         WAIT_HIGH: if (rxs) next = IDLE;
         default:   next = IDLE;
      endcase
   end

   always_comb begin
      sample    = timer == '0 && (state == START || state == DATA || state == STOP);
      done      = sample && state == STOP && rxs;
      frame_err = sample && state == STOP && !rxs;
   end

   always_ff @(posedge i_clk)
      if (i_rst) begin
         timer   <= '0;
         bit_idx <= '0;
         shift   <= '0;
         o_data  <= '0;
         o_rdy   <= 1'b0;
         o_ferr  <= 1'b0;
         o_ovr   <= 1'b0;
      end else begin
         o_ferr <= frame_err;
         o_ovr  <= done && o_rdy && !i_rd;
         if (state == IDLE && !rxs) timer <= HALF_LOAD;
         else if (sample) timer <= BAUD_LOAD;
         else if (timer != '0) timer <= timer - 1'b1;
         if (sample && state == START) bit_idx <= '0;
         if (sample && state == DATA) begin
            shift   <= {rxs, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
         // a completing byte may replace the held one only if it is read now
         if (done && (!o_rdy || i_rd)) begin
            o_data <= shift;
            o_rdy  <= 1'b1;
         end else if (i_rd) o_rdy <= 1'b0;
      end
endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: directed frames against serial_rx at 104 clocks per bit.
module tb_serial_rx;
   localparam int BAUD_DIV = 104;
   localparam int HALF_DIV = 52;

   logic       clk = 1'b0;
   logic       rst, rx, rd;
   logic       rdy, ferr, ovr;
   logic [7:0] data;
   int         checks = 0, errors = 0;
   int         cyc = 0, ferr_cnt = 0, ovr_cnt = 0, rise_cyc = -1;
   int         f0, base;
   logic       prev_rdy = 1'b0;

   serial_rx dut (
      .i_clk(clk), .i_rst(rst), .i_rx(rx), .i_rd(rd),
      .o_rdy(rdy), .o_data(data), .o_ferr(ferr), .o_ovr(ovr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // pulse counters count high cycles, so a stretched pulse shows up as 2
   always @(negedge clk) begin
      ferr_cnt += int'(ferr);
      ovr_cnt  += int'(ovr);
      if (rdy && !prev_rdy) rise_cyc = cyc;
      prev_rdy = rdy;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic stop, input int rd_at);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int k = 0; k < 10 * BAUD_DIV; k++) begin
         rx = f[k / BAUD_DIV];
         rd = (k == rd_at);
         @(negedge clk);
      end
      rd = 1'b0;
      rx = 1'b1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic read_pulse();
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [9:0] fr;
      rst = 1'b1; rx = 1'b1; rd = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rdy", rdy, 0);
      check("rst_data", data, 8'h00);
      check("rst_ferr", ferr, 0);
      check("rst_ovr", ovr, 0);
      check("rst_state", dut.state, 0);
      rst = 1'b0;
      idle(10);

      f0 = cyc;
      send(8'h55, 1'b1, -1);
      idle(10);
      check("t55_latency", rise_cyc - f0, 2 + HALF_DIV + 9 * BAUD_DIV + 1);
      check("t55_data", data, 8'h55);
      check("t55_rdy", rdy, 1);
      check("t55_ferr", ferr_cnt, 0);
      check("t55_ovr", ovr_cnt, 0);
      read_pulse();
      check("t55_rd_clear", rdy, 0);

      rx = 1'b0;
      repeat (30) @(negedge clk);
      idle(300);
      check("glitch_rdy", rdy, 0);
      check("glitch_ferr", ferr_cnt, 0);
      check("glitch_state", dut.state, 0);
      send(8'hC3, 1'b1, -1);
      idle(10);
      check("c3_data", data, 8'hC3);
      check("c3_rdy", rdy, 1);
      read_pulse();

      send(8'hA5, 1'b0, -1);
      rx = 1'b0;
      repeat (2000) @(negedge clk);
      check("break_rdy", rdy, 0);
      check("break_state", dut.state, 4);
      idle(200);
      check("break_ferr", ferr_cnt, 1);
      check("break_rdy_after", rdy, 0);
      send(8'h3C, 1'b1, -1);
      idle(10);
      check("3c_data", data, 8'h3C);
      check("3c_rdy", rdy, 1);
      check("3c_ferr", ferr_cnt, 1);
      read_pulse();

      send(8'h11, 1'b1, -1);
      send(8'h22, 1'b1, -1);
      idle(10);
      check("ovr_data", data, 8'h11);
      check("ovr_rdy", rdy, 1);
      check("ovr_pulse", ovr_cnt, 1);
      read_pulse();
      check("ovr_rd_clear", rdy, 0);

      send(8'h11, 1'b1, -1);
      idle(10);
      check("rdhit_first", data, 8'h11);
      send(8'h22, 1'b1, 2 + HALF_DIV + 9 * BAUD_DIV);
      idle(10);
      check("rdhit_data", data, 8'h22);
      check("rdhit_rdy", rdy, 1);
      check("rdhit_ovr", ovr_cnt, 1);

      fr = {1'b1, 8'h99, 1'b0};
      for (int k = 0; k < 5 * BAUD_DIV + 50; k++) begin
         rx = fr[k / BAUD_DIV];
         @(negedge clk);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rx = 1'b1;
      @(negedge clk);
      check("midrst_rdy", rdy, 0);
      check("midrst_data", data, 8'h00);
      check("midrst_ferr", ferr, 0);
      check("midrst_ovr", ovr, 0);
      check("midrst_state", dut.state, 0);
      idle(300);
      check("midrst_quiet", rdy, 0);
      send(8'h7E, 1'b1, -1);
      idle(10);
      check("7e_data", data, 8'h7E);
      check("7e_rdy", rdy, 1);
      check("final_ferr", ferr_cnt, 1);
      check("final_ovr", ovr_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 Parameter CLK_FREQ, default 12_000_000, i_clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115_200, line bit rate; BAUD_DIV = CLK_FREQ / BAUD_RATE (integer division, 104 at defaults); HALF_DIV = BAUD_DIV / 2.
REQ-003 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 i_rst  input  1  reset; synchronous and active-high.
REQ-005 i_rx  input  1  asynchronous serial line, 8N1, LSB first, idle high.
REQ-006 i_rd  input  1  consumer read strobe; one cycle high consumes the held byte.
REQ-007 o_rdy  output  1  high while a received byte is held in o_data.
REQ-008 o_data  output  8  held received byte; valid only while o_rdy is high.
REQ-009 o_ferr  output  1  one-cycle pulse on framing error (stop bit sampled low).
REQ-010 o_ovr  output  1  one-cycle pulse on overrun (byte completed while the previous byte was still held and not read).

Function
REQ-011 i_rx shall pass through a two-flip-flop synchronizer whose stages reset to 1; all FSM decisions use the synchronized value (rxs).
REQ-012 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-013 IDLE: on the first cycle with rxs==0, go to START and load the bit-timer with HALF_DIV-1.
REQ-014 The bit-timer decrements every cycle; a sample event occurs on the cycle it reads 0, and it then reloads with BAUD_DIV-1.
REQ-015 START: at the sample event, rxs==0 goes to DATA with bit index 0; rxs==1 (glitch) returns to IDLE with no output activity.
REQ-016 DATA: at each sample event, shift rxs into shift-register bit 7 (right shift, LSB first); after the 8th sample, go to STOP.
REQ-017 STOP: at the sample event, rxs==1 completes the byte and returns to IDLE; rxs==0 pulses o_ferr, discards the byte, and goes to WAIT_HIGH.
REQ-018 WAIT_HIGH: remain until rxs==1, then go to IDLE; this prevents a held-low line (break) from producing further frames.
REQ-019 Timing: the stop sample occurs HALF_DIV + 9*BAUD_DIV cycles after IDLE first sees rxs==0; o_rdy/o_data update on the following cycle.
REQ-020 On completion with o_rdy==0: o_data <= byte, and o_rdy <= 1.
REQ-021 On completion with o_rdy==1 and i_rd==1 in the same cycle: o_data <= new byte, o_rdy stays 1, no o_ovr.
REQ-022 On completion with o_rdy==1 and i_rd==0: o_data and o_rdy are unchanged (old byte kept), the new byte is dropped, and o_ovr pulses.
REQ-023 i_rd with o_rdy==1 and no completion clears o_rdy next cycle; i_rd with o_rdy==0 is ignored.
REQ-024 o_ferr and o_ovr are registered and never high for two consecutive cycles from one event.

Reset
REQ-025 i_rst shall force: state IDLE, synchronizer stages 1, bit-timer and bit index 0, shift register 0, o_data 8'h00, o_rdy 0, o_ferr 0, and o_ovr 0.
REQ-026 Reset asserted mid-frame shall discard the partial byte; reception resumes only on the next falling edge seen after reset releases.

Structure
REQ-027 No shared package: BAUD_DIV, HALF_DIV, and the state encodings are localparams inside serial_rx; timer width is $clog2(BAUD_DIV).
REQ-028 No sub-module; the synchronizer, bit-timer, and FSM are implemented inline.
REQ-029 The module sits between the board RX pad (SB_IO input) and the CPU's receive interface.

Verification (CLK_FREQ=12_000_000, BAUD_RATE=115_200, 104 cycles/bit)
REQ-030 Frame 0x55 -> o_rdy rises exactly HALF_DIV+9*104+1 cycles after synchronized start detect; o_data=0x55; o_ferr=o_ovr=0.
REQ-031 Low glitch of 30 cycles on idle line -> no o_rdy, no o_ferr; FSM back in IDLE; a following 0xC3 frame is received correctly.
REQ-032 0xA5 with stop bit 0, then line held low 2000 cycles, then high, then 0x3C -> single o_ferr pulse, o_rdy stays 0 until 0x3C arrives, and o_data=0x3C.
REQ-033 Back-to-back 0x11, 0x22 with no i_rd -> o_data=0x11, one o_ovr pulse at 0x22 completion; i_rd then clears o_rdy.
REQ-034 0x11 held; i_rd asserted on the exact completion cycle of 0x22 -> o_data=0x22, o_rdy=1, and o_ovr=0.
REQ-035 i_rst pulsed during data bit 4 of 0x99 -> all outputs at reset values; the next full frame 0x7E gives o_data=0x7E.
